// File: rtl/imem_ctrl.sv
// Byte-addressed instruction/data memory behind a single-outstanding valid/ready
// controller with configurable read latency, byte enables and endianness.
module imem_ctrl #(
    parameter int unsigned DEPTH      = 4096,
    parameter int unsigned AW         = 32,
    parameter bit          BIG_ENDIAN = 1'b1,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_wr,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    input  logic [3:0]    req_be,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic          busy
);
    localparam int unsigned IW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e        state_q;
    logic [1:0]    cnt_q;
    logic [IW-1:0] addr_q;
    logic          wr_q;
    logic          err_q;
    logic          req_ready_q;
    logic          rsp_valid_q;
    logic [31:0]   rsp_rdata_q;
    logic          rsp_err_q;
    logic          busy_q;

    logic [7:0]    mem_q [DEPTH];

    logic          accept;
    logic          req_err;
    logic [31:0]   rd_word_d;

    // Byte offset (from the word address) that holds data lane l (lane 0 = D[7:0]).
    function automatic logic [1:0] lane_off(input int unsigned l);
        return BIG_ENDIAN ? 2'(3 - l) : 2'(l);
    endfunction

    assign accept  = (state_q == IDLE) && req_ready_q && req_valid;
    // Upper address bits only feed the range check, so high addresses never alias.
    assign req_err = (req_addr[1:0] != 2'b00) || (req_addr > AW'(DEPTH - 4));

    always_ff @(posedge clk) begin
        if (accept && req_wr && !req_err) begin
            for (int unsigned l = 0; l < 4; l++) begin
                if (req_be[l]) begin
                    mem_q[req_addr[IW-1:0] + IW'(lane_off(l))] <= req_wdata[8*l +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_word_d = '0;
        for (int unsigned l = 0; l < 4; l++) begin
            rd_word_d[8*l +: 8] = mem_q[addr_q + IW'(lane_off(l))];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q     <= WAIT;
                        cnt_q       <= '0;
                        addr_q      <= req_addr[IW-1:0];
                        wr_q        <= req_wr;
                        err_q       <= req_err;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_q == 2'(RD_LAT - 1)) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= err_q;
                        rsp_rdata_q <= (!wr_q && !err_q) ? rd_word_d : '0;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_imem_ctrl.sv
// Bench for imem_ctrl: three instances (BE lat1, BE lat3, LE lat4) against an
// edge-counting transaction model over a plain byte array.
module tb_imem_ctrl;
    localparam int N     = 3;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset     [N];
    logic        req_valid [N];
    logic        req_ready [N];
    logic        req_wr    [N];
    logic [31:0] req_addr  [N];
    logic [31:0] req_wdata [N];
    logic [3:0]  req_be    [N];
    logic        rsp_valid [N];
    logic        rsp_ready [N];
    logic [31:0] rsp_rdata [N];
    logic        rsp_err   [N];
    logic        busy      [N];

    for (genvar g = 0; g < N; g++) begin : gen_dut
        imem_ctrl #(
            .DEPTH     (DEPTH),
            .AW        (32),
            .BIG_ENDIAN(g == 2 ? 1'b0 : 1'b1),
            .RD_LAT    (g == 0 ? 1 : (g == 1 ? 3 : 4))
        ) u_dut (
            .clk      (clk),
            .reset    (reset[g]),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_wr   (req_wr[g]),
            .req_addr (req_addr[g]),
            .req_wdata(req_wdata[g]),
            .req_be   (req_be[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_ready(rsp_ready[g]),
            .rsp_rdata(rsp_rdata[g]),
            .rsp_err  (rsp_err[g]),
            .busy     (busy[g])
        );
    end

    int tests = 0;
    int fails = 0;

    function automatic int lat(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
    endfunction

    function automatic bit big(input int i);
        return i != 2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte array plus the edge number at which each response is due.
    logic [7:0]  mm     [N][DEPTH];
    bit          m_out  [N];
    bit          m_ready[N];
    bit          m_valid[N];
    logic [31:0] m_rd   [N];
    bit          m_err  [N];
    logic [31:0] p_rd   [N];
    bit          p_err  [N];
    int          m_due  [N];
    int          edge_cnt = 0;

    function automatic logic [31:0] model_read(input int i, input int a);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            if (big(i)) w = {w[23:0], mm[i][a+k]};
            else        w[8*k +: 8] = mm[i][a+k];
        end
        return w;
    endfunction

    task automatic model_step(input int i);
        int  sh;
        int  a;
        if (!reset[i]) begin
            m_out[i] = 0; m_ready[i] = 0; m_valid[i] = 0; m_rd[i] = '0; m_err[i] = 0;
        end else if (m_out[i]) begin
            if (m_valid[i]) begin
                if (rsp_ready[i]) begin
                    m_out[i] = 0; m_valid[i] = 0;
                end
            end else if (edge_cnt == m_due[i]) begin
                m_valid[i] = 1; m_rd[i] = p_rd[i]; m_err[i] = p_err[i];
            end
        end else if (m_ready[i] && req_valid[i]) begin
            m_ready[i] = 0;
            m_out[i]   = 1;
            m_due[i]   = edge_cnt + lat(i);
            p_err[i]   = (req_addr[i] % 4 != 0) || (req_addr[i] > 32'(DEPTH - 4));
            p_rd[i]    = '0;
            a = int'(req_addr[i] % DEPTH);
            if (!p_err[i]) begin
                if (req_wr[i]) begin
                    for (int k = 0; k < 4; k++) begin
                        sh = big(i) ? 8 * (3 - k) : 8 * k;
                        if (req_be[i][sh/8]) mm[i][a+k] = 8'(req_wdata[i] >> sh);
                    end
                end else begin
                    p_rd[i] = model_read(i, a);
                end
            end
        end else begin
            m_ready[i] = 1;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            edge_cnt++;
            for (int i = 0; i < N; i++) model_step(i);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                chk($sformatf("d%0d.req_ready", i), 32'(req_ready[i]), 32'(m_ready[i]));
                chk($sformatf("d%0d.rsp_valid", i), 32'(rsp_valid[i]), 32'(m_valid[i]));
                chk($sformatf("d%0d.busy", i),      32'(busy[i]),      32'(m_out[i]));
                chk($sformatf("d%0d.rsp_rdata", i), rsp_rdata[i],      m_rd[i]);
                chk($sformatf("d%0d.rsp_err", i),   32'(rsp_err[i]),   32'(m_err[i]));
            end
        end
    end

    task automatic txn(input int i, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be, input int hold,
                       output logic [31:0] rd, output logic err);
        int k;
        @(negedge clk);
        req_valid[i] = 1'b1; req_wr[i] = wr; req_addr[i] = addr;
        req_wdata[i] = wd;   req_be[i] = be; rsp_ready[i] = (hold == 0);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!m_out[i] && k < 50);
        chk($sformatf("d%0d.accept", i), 32'(m_out[i]), 32'd1);
        // Garbage on the request side while busy must be ignored.
        req_valid[i] = 1'($urandom_range(0, 1)); req_wr[i] = 1'($urandom_range(0, 1));
        req_addr[i]  = $urandom;                 req_wdata[i] = $urandom;
        req_be[i]    = 4'($urandom);
        k = 0;
        while (rsp_valid[i] !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("d%0d.latency", i), 32'(k), 32'(lat(i)));
        repeat (hold) @(negedge clk);
        rsp_ready[i] = 1'b1;
        k = 0;
        while (m_out[i] && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("d%0d.done", i), 32'(m_out[i]), 32'd0);
        req_valid[i] = 1'b0;
        chk($sformatf("d%0d.ready_gap", i), 32'(req_ready[i]), 32'd0);
        rd  = rsp_rdata[i];
        err = rsp_err[i];
    endtask

    initial begin
        #1_000_000;
        fails++;
        $display("FAIL global_timeout: got still running expected finished");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

    logic [31:0] rd, saved;
    logic        err;
    int          r;
    logic [31:0] a;

    initial begin
        for (int i = 0; i < N; i++) begin
            reset[i] = 1'b1; req_valid[i] = 1'b0; req_wr[i] = 1'b0; req_addr[i] = '0;
            req_wdata[i] = '0; req_be[i] = '0; rsp_ready[i] = 1'b1;
        end
        #1;
        for (int i = 0; i < N; i++) reset[i] = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.req_ready", 32'(req_ready[0]), 32'd0);
        chk("rst.rsp_rdata", rsp_rdata[1], 32'd0);
        #2;
        for (int i = 0; i < N; i++) reset[i] = 1'b1;
        @(negedge clk);
        chk("rel.req_ready", 32'(req_ready[0]), 32'd1);

        for (int i = 0; i < N; i++)
            for (int w = 0; w < DEPTH / 4; w++)
                txn(i, 1'b1, 32'(w * 4), $urandom, 4'hF, 0, rd, err);

        // Big endian, latency 1
        txn(0, 1'b1, 32'h10, 32'h1234_5678, 4'hF, 0, rd, err);
        chk("be.wr_err", 32'(err), 32'd0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, err);
        chk("be.rd", rd, 32'h1234_5678);
        chk("be.rd_err", 32'(err), 32'd0);
        chk("be.byte10", 32'(gen_dut[0].u_dut.mem_q[16]), 32'h12);
        chk("model.be_rd", model_read(0, 16), 32'h1234_5678);
        txn(0, 1'b1, 32'h10, 32'hAABB_CCDD, 4'b0101, 0, rd, err);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1, rd, err);
        chk("be.partial", rd, 32'h12BB_56DD);
        txn(0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, 0, rd, err);
        chk("be.zero_err", 32'(err), 32'd0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, err);
        chk("be.zero_keep", rd, 32'h12BB_56DD);
        txn(0, 1'b0, 32'h12, 32'h0, 4'h0, 0, rd, err);
        chk("err.misalign", 32'(err), 32'd1);
        chk("err.misalign_rd", rd, 32'd0);
        saved = model_read(0, DEPTH - 4);
        txn(0, 1'b1, 32'(DEPTH - 2), 32'hFFFF_FFFF, 4'hF, 0, rd, err);
        chk("err.wr_top", 32'(err), 32'd1);
        txn(0, 1'b0, 32'(DEPTH - 4), 32'h0, 4'h0, 0, rd, err);
        chk("top.err", 32'(err), 32'd0);
        chk("top.unchanged", rd, saved);
        txn(0, 1'b1, 32'h0001_0010, 32'h0, 4'hF, 0, rd, err);
        chk("err.highbits", 32'(err), 32'd1);
        txn(0, 1'b0, 32'(DEPTH), 32'h0, 4'h0, 0, rd, err);
        chk("err.depth", 32'(err), 32'd1);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, err);
        chk("noalias", rd, 32'h12BB_56DD);

        // Latency 3 with backpressure
        txn(1, 1'b1, 32'h40, 32'h0BAD_BEEF, 4'hF, 5, rd, err);
        txn(1, 1'b0, 32'h40, 32'h0, 4'h0, 5, rd, err);
        chk("lat3.rd", rd, 32'h0BAD_BEEF);

        // Little endian, latency 4
        txn(2, 1'b1, 32'h20, 32'h1234_5678, 4'hF, 0, rd, err);
        chk("le.byte20", 32'(gen_dut[2].u_dut.mem_q[32]), 32'h78);
        chk("le.byte23", 32'(gen_dut[2].u_dut.mem_q[35]), 32'h12);
        chk("model.le_rd", model_read(2, 32), 32'h1234_5678);
        txn(2, 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, err);
        chk("le.rd", rd, 32'h1234_5678);

        // Reset two cycles into a latency-4 write
        @(negedge clk);
        req_valid[2] = 1'b1; req_wr[2] = 1'b1; req_addr[2] = 32'h30;
        req_wdata[2] = 32'hCAFE_F00D; req_be[2] = 4'hF;
        r = 0;
        do begin
            @(negedge clk);
            r++;
        end while (!m_out[2] && r < 50);
        chk("mid.accept", 32'(m_out[2]), 32'd1);
        req_valid[2] = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset[2] = 1'b0;
        #1;
        chk("mid.req_ready", 32'(req_ready[2]), 32'd0);
        chk("mid.rsp_valid", 32'(rsp_valid[2]), 32'd0);
        chk("mid.busy", 32'(busy[2]), 32'd0);
        chk("mid.rsp_err", 32'(rsp_err[2]), 32'd0);
        chk("mid.rsp_rdata", rsp_rdata[2], 32'd0);
        repeat (2) @(negedge clk);
        #2 reset[2] = 1'b1;
        @(negedge clk);
        chk("mid.ready_after", 32'(req_ready[2]), 32'd1);
        txn(2, 1'b0, 32'h30, 32'h0, 4'h0, 0, rd, err);
        chk("mid.kept", rd, 32'hCAFE_F00D);

        for (int i = 0; i < N; i++) begin
            for (int t = 0; t < 80; t++) begin
                r = $urandom_range(0, 7);
                if (r < 6)       a = 32'($urandom_range(0, DEPTH / 4 - 1) * 4);
                else if (r == 6) a = 32'($urandom_range(0, DEPTH - 1));
                else             a = $urandom | 32'(DEPTH);
                txn(i, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom),
                    $urandom_range(0, 3), rd, err);
            end
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/imem_ctrl.md
Name: imem_ctrl

Overview:
Parametrised, byte-addressed instruction/data memory with a valid/ready request-response interface, configurable read latency, byte-enable writes, selectable endianness and access-error reporting. It replaces the fixed 4096x8 instruction store with a tuneable array behind a single-outstanding-transaction controller. The CPU fetch stage, or a loader, sits on the request side. The response side feeds the IF/ID path.

Parameters:
DEPTH, 4096, memory size in bytes; power of 2, >= 16
AW, 32, request address width
BIG_ENDIAN, 1, 1 = MSB at lowest byte address; 0 = LSB at lowest byte address
RD_LAT, 1, cycles from request accept to response valid; legal range 1..4

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_wr  in  1  1 = write, 0 = read
req_addr  in  AW  byte address of word
req_wdata  in  32  write data
req_be  in  4  byte enables; be[3] = D[31:24] ... be[0] = D[7:0]
rsp_valid  out  1  response present
rsp_ready  in  1  consumer takes response
rsp_rdata  out  32  read data; 0 for writes and errors
rsp_err  out  1  access error
busy  out  1  state != IDLE

Behaviour:
- States:
  - IDLE: req_ready=1.
  - WAIT: counter runs RD_LAT cycles.
  - RESP: rsp_valid=1.
- Reset (reset=0, asynchronous):
  - State goes to IDLE, counter to 0.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
  - req_ready rises on the first clk edge after reset is released.
  - Memory array is not cleared.
- Accept: a request is accepted on an edge where state=IDLE, req_ready=1 and req_valid=1.
  - At that edge, latch addr, wr, wdata and be; move to WAIT with cnt=0.
- Error check at accept: err = (addr[1:0] != 0) OR (addr > DEPTH-4).
  - An erroring request never writes the array. It still takes the normal RD_LAT path.
- Write commit: on the accept edge, write each byte whose be bit is set, provided err=0.
  - BIG_ENDIAN=1: byte addr+0 <= D[31:24], +1 <= D[23:16], +2 <= D[15:8], +3 <= D[7:0].
  - BIG_ENDIAN=0: addr+0 <= D[7:0], +1 <= D[15:8], +2 <= D[23:16], +3 <= D[31:24].
  - be=4'b0000 writes nothing and returns a normal (non-error) response.
- WAIT: cnt increments each edge.
  - On the edge where cnt == RD_LAT-1: go to RESP and register rsp_valid=1 and rsp_err=err.
  - On that same edge, rsp_rdata = (read && !err) ? assembled word from latched addr : 0.
  - Read assembly mirrors the write byte ordering above.
- Latency: accept at edge E0 gives rsp_valid high starting after edge E(RD_LAT).
  - A read that follows a write to the same word returns the new data.
- RESP: rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready=1.
  - On the edge with rsp_valid and rsp_ready both high: return to IDLE and clear rsp_valid.
  - rsp_rdata and rsp_err hold their last values.
  - req_ready returns the following cycle; there is no same-cycle accept in RESP.
- req_valid, or any change to req_* inputs, while not IDLE is ignored. The requester must hold its request until it is accepted.
- Reset mid-transaction:
  - The transaction is aborted and no response is produced.
  - A write already committed at its accept edge remains in the array.
- Address bits above log2(DEPTH) count only toward the out-of-range check. They never alias.

Test Plan:
- Big-endian write/read (BIG_ENDIAN=1, RD_LAT=1): write 0x1234_5678 @0x10, be=F, then read @0x10 -> rsp_rdata=0x1234_5678, rsp_err=0. Read byte 0x10 directly -> 0x12. rsp_valid rises exactly 1 cycle after each accept.
- Byte enables: after the first test, write 0xAABB_CCDD @0x10 with be=4'b0101 -> read returns 0x12BB_56DD. A write with be=0 leaves 0x12BB_56DD and returns rsp_err=0.
- Errors:
  - Read @0x12 (misaligned) -> rsp_err=1, rsp_rdata=0.
  - Write @DEPTH-2 -> rsp_err=1 and the array is unchanged.
  - Read @DEPTH-4 -> rsp_err=0.
- Latency and backpressure (RD_LAT=3): accept at E0 -> rsp_valid first high after E3. Hold rsp_ready=0 for 5 cycles -> outputs stable and req_ready=0 throughout. Raise rsp_ready -> back to IDLE, and the next request is accepted no earlier than 1 cycle later.
- Little endian (BIG_ENDIAN=0): write 0x1234_5678 @0x20 -> byte 0x20=0x78 and byte 0x23=0x12. Read returns 0x1234_5678.
- Reset mid-op (RD_LAT=4): assert reset 2 cycles after accepting a write of 0xCAFE_F00D @0x30 -> all outputs go to 0 immediately and no response follows. After release and 1 edge, req_ready=1, and a read @0x30 returns 0xCAFE_F00D.
